pwr_cntr_bank: RTL and testbench
================================

PWR_CNTR_BANK -- requirements
Module: pwr_cntr_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of monitored channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: width of each energy accumulator.
REQ-003 SHALL have parameter WGT_W, default 8: width of each per-channel energy weight.
REQ-004 SHALL have parameter ADDR_W, default 4: width of the register address; 2^ADDR_W >= NUM_CH.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_L, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port mon, input, NUM_CH: monitored nets, synchronous to clk, one bit per channel.
REQ-008 SHALL have port enable, input, 1: high = accumulation allowed.
REQ-009 SHALL have port addr, input, ADDR_W: channel index for read/write.
REQ-010 SHALL have port sel, input, 1: 0 = accumulator, 1 = weight register.
REQ-011 SHALL have port wr_en, input, 1: write strobe.
REQ-012 SHALL have port wr_data, input, CNT_W: write data; for weights, only the low WGT_W bits are used.
REQ-013 SHALL have port rd_en, input, 1: read strobe.
REQ-014 SHALL have port rd_data, output, CNT_W: read data; weight reads zero-extended.
REQ-015 SHALL have port rd_valid, output, 1: rd_data valid for one cycle.
REQ-016 SHALL have port clr_all, input, 1: pulse that starts a clear of all accumulators.
REQ-017 SHALL have port busy, output, 1: high while the clear sweep runs.
REQ-018 SHALL have port sat, output, NUM_CH: sticky per-channel saturation flags.

Function
REQ-019 SHALL register mon each cycle in mon_q; event[i] = mon[i] & ~mon_q[i] (0->1 transition).
REQ-020 SHALL add weight[i] to acc[i] in the cycle after an event when enable=1 and state=IDLE.
REQ-021 SHALL saturate acc[i] at 2^CNT_W-1 instead of wrapping, and SHALL set sat[i] when a sum overflows or equals the maximum.
REQ-022 SHALL keep updating mon_q while enable=0, but events seen with enable=0 SHALL NOT accumulate.
REQ-023 SHALL, on a write to an accumulator (wr_en=1, sel=0, addr<NUM_CH, state=IDLE), load acc[addr]=wr_data and clear sat[addr]; the write takes priority over a same-cycle event on that channel.
REQ-024 SHALL, on a weight write (sel=1), load weight[addr]=wr_data[WGT_W-1:0].
REQ-025 SHALL ignore writes with addr>=NUM_CH.
REQ-026 SHALL have read latency 1: with rd_en at cycle t, rd_data/rd_valid are valid at t+1, showing the value at t before any update at t.
REQ-027 SHALL return rd_data=0 with rd_valid=1 for addr>=NUM_CH.
REQ-028 SHALL, when rd_en=0, drive rd_valid=0 and hold rd_data at its last value.
REQ-029 SHALL implement FSM IDLE->CLEAR on clr_all=1 in IDLE; clr_all SHALL be ignored while in CLEAR.
REQ-030 SHALL, in CLEAR, zero acc[k] and sat[k] for k = 0..NUM_CH-1, one per cycle; CLEAR->IDLE after k=NUM_CH-1.
REQ-031 SHALL hold busy=1 for exactly NUM_CH cycles.
REQ-032 SHALL, in CLEAR, suspend accumulation and accumulator writes; weight writes and reads SHALL still be served.
REQ-033 SHALL apply clr_all with priority over a same-cycle wr_en; that write is dropped.

Reset
REQ-034 SHALL, on reset_L=0, set asynchronously: acc=0, sat=0, weight=1 for every channel, mon_q=0, state=IDLE, busy=0, rd_valid=0, rd_data=0.
REQ-035 SHALL abort a CLEAR sweep on reset mid-sweep and return to the REQ-034 values.
REQ-036 SHALL count no event on the first cycle after reset release if mon=0; if mon[i]=1 at release, one event SHALL be counted for each such channel.

Verification
REQ-037 SHALL pass: set weight[0]=3, enable=1, toggle mon[0] 0->1 five times -> reading acc[0] returns 15 and sat[0]=0.
REQ-038 SHALL pass: CNT_W=8, weight[1]=200, two events on ch1 -> acc[1]=255 and sat[1]=1; writing 0 to acc[1] clears sat[1].
REQ-039 SHALL pass: with mon held at 1 for 10 cycles and enable=1 -> exactly one event counted per channel.
REQ-040 SHALL pass: clr_all with NUM_CH=4 -> busy high for 4 cycles; all acc=0 afterward; events during busy are not counted.
REQ-041 SHALL pass: write acc[2]=100 in the same cycle as an event on ch2 -> acc[2]=100; rd_en on addr=7 -> rd_data=0 and rd_valid=1 one cycle later.
REQ-042 SHALL pass: reset_L asserted during cycle 2 of a CLEAR sweep -> busy=0 immediately and all weights read back as 1.

Source files
------------

// File: rtl/pwr_cntr_bank.sv
// Per-channel weighted energy counter bank. Rising edges on mon add a
// programmable weight into saturating accumulators, with register access and a sequential clear sweep.
module pwr_cntr_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int WGT_W  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [NUM_CH-1:0] mon,
    input  logic              enable,
    input  logic [ADDR_W-1:0] addr,
    input  logic              sel,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic              rd_en,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              clr_all,
    output logic              busy,
    output logic [NUM_CH-1:0] sat
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CH - 1);
    localparam logic [CNT_W:0]    MAX_EXT  = {1'b0, {CNT_W{1'b1}}};

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  clr_idx_q, clr_idx_d;
    logic [NUM_CH-1:0]  mon_q;
    logic [NUM_CH-1:0]  sat_q, sat_d;
    logic [CNT_W-1:0]   acc_q [NUM_CH];
    logic [CNT_W-1:0]   acc_d [NUM_CH];
    logic [WGT_W-1:0]   wgt_q [NUM_CH];
    logic [WGT_W-1:0]   wgt_d [NUM_CH];
    logic [CNT_W:0]     sum   [NUM_CH];
    logic [CNT_W-1:0]   rd_data_q, rd_data_d;
    logic               rd_valid_q;
    logic [NUM_CH-1:0]  evt;
    logic [NUM_CH-1:0]  addr_hit;
    logic               idle, clr_go, acc_wr, wgt_wr;

    assign evt    = mon & ~mon_q;
    assign idle   = (state_q == ST_IDLE);
    assign clr_go = idle & clr_all;
    // A clear request in IDLE wins over any same-cycle write.
    assign acc_wr = wr_en & ~sel & idle & ~clr_all;
    assign wgt_wr = wr_en & sel & ~clr_go;

    always_comb begin
        addr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            addr_hit[i] = (addr == ADDR_W'(i));
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_all) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i] = {1'b0, acc_q[i]} + (CNT_W + 1)'(wgt_q[i]);
        end
    end

    always_comb begin
        sat_d = sat_q;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = acc_q[i];
            wgt_d[i] = wgt_q[i];
            if (idle && enable && evt[i]) begin
                if (sum[i] >= MAX_EXT) begin
                    acc_d[i] = '1;
                    sat_d[i] = 1'b1;
                end else begin
                    acc_d[i] = sum[i][CNT_W-1:0];
                end
            end
            if (acc_wr && addr_hit[i]) begin
                acc_d[i] = wr_data;
                sat_d[i] = 1'b0;
            end
            if (wgt_wr && addr_hit[i]) begin
                wgt_d[i] = wr_data[WGT_W-1:0];
            end
            if (!idle && clr_idx_q == ADDR_W'(i)) begin
                acc_d[i] = '0;
                sat_d[i] = 1'b0;
            end
        end
    end

    // Reads return pre-update contents; unmapped addresses read as zero.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (addr_hit[i]) begin
                    rd_data_d = sel ? CNT_W'(wgt_q[i]) : acc_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_IDLE;
            clr_idx_q  <= '0;
            mon_q      <= '0;
            sat_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                wgt_q[i] <= WGT_W'(1);
            end
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            mon_q      <= mon;
            sat_q      <= sat_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
                wgt_q[i] <= wgt_d[i];
            end
        end
    end

    assign busy     = (state_q == ST_CLEAR);
    assign sat      = sat_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_pwr_cntr_bank.sv
// Bench for pwr_cntr_bank: directed scenarios then random traffic, checked
// every cycle against an integer-arithmetic model of the counter bank.
module tb_pwr_cntr_bank;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int WGT_W  = 8;
  localparam int ADDR_W = 4;
  localparam int MAXV   = 255;

  logic              clk = 1'b0;
  logic              reset_L = 1'b0;
  logic [NUM_CH-1:0] mon = '0;
  logic              enable = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic              sel = 1'b0;
  logic              wr_en = 1'b0;
  logic [CNT_W-1:0]  wr_data = '0;
  logic              rd_en = 1'b0;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;
  logic              clr_all = 1'b0;
  logic              busy;
  logic [NUM_CH-1:0] sat;

  int total = 0;
  int bad = 0;

  // reference model state
  int m_acc [NUM_CH];
  int m_wgt [NUM_CH];
  bit m_sat [NUM_CH];
  bit m_prev [NUM_CH];
  int m_clear_left;
  int m_clear_idx;
  int m_rd_data;
  bit m_rd_valid;

  pwr_cntr_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WGT_W(WGT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_L(reset_L), .mon(mon), .enable(enable), .addr(addr),
    .sel(sel), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .clr_all(clr_all),
    .busy(busy), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_acc[i] = 0;
      m_wgt[i] = 1;
      m_sat[i] = 0;
      m_prev[i] = 0;
    end
    m_clear_left = 0;
    m_clear_idx = 0;
    m_rd_data = 0;
    m_rd_valid = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [NUM_CH-1:0] s;
    for (int i = 0; i < NUM_CH; i++) s[i] = m_sat[i];
    chk({tag, "_busy"}, 32'(busy), 32'(m_clear_left != 0));
    chk({tag, "_sat"}, 32'(sat), 32'(s));
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(m_rd_valid));
    chk({tag, "_rd_data"}, 32'(rd_data), 32'(m_rd_data));
  endtask

  // Advance the model by one clock using the inputs currently driven, then
  // let the DUT take the same edge and compare.
  task automatic cycle(input string tag);
    bit clearing;
    bit clr_go;
    int a;
    int s;
    clearing = (m_clear_left != 0);
    clr_go = !clearing && clr_all;
    a = int'(addr);
    if (rd_en) begin
      m_rd_valid = 1;
      if (a < NUM_CH) m_rd_data = sel ? m_wgt[a] : m_acc[a];
      else m_rd_data = 0;
    end else begin
      m_rd_valid = 0;
    end
    if (!clearing && enable) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (mon[i] && !m_prev[i]) begin
          s = m_acc[i] + m_wgt[i];
          if (s >= MAXV) begin
            m_acc[i] = MAXV;
            m_sat[i] = 1;
          end else begin
            m_acc[i] = s;
          end
        end
      end
    end
    if (wr_en && a < NUM_CH && !clr_go) begin
      if (sel) begin
        m_wgt[a] = int'(wr_data) % 256;
      end else if (!clearing) begin
        m_acc[a] = int'(wr_data);
        m_sat[a] = 0;
      end
    end
    if (clearing) begin
      m_acc[m_clear_idx] = 0;
      m_sat[m_clear_idx] = 0;
      m_clear_idx++;
      m_clear_left--;
    end else if (clr_go) begin
      m_clear_left = NUM_CH;
      m_clear_idx = 0;
    end
    for (int i = 0; i < NUM_CH; i++) m_prev[i] = mon[i];
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic write_reg(input bit s, input int a, input int d);
    wr_en = 1'b1;
    sel = s;
    addr = ADDR_W'(a);
    wr_data = CNT_W'(d);
    cycle("write");
    wr_en = 1'b0;
  endtask

  task automatic read_reg(input bit s, input int a);
    rd_en = 1'b1;
    sel = s;
    addr = ADDR_W'(a);
    cycle("read");
    rd_en = 1'b0;
  endtask

  initial begin
    int bc;
    model_reset();
    #1;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    #2;
    reset_L = 1'b1;
    cycle("idle0");

    // weight 3, five rising edges on ch0
    write_reg(1'b1, 0, 3);
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mon = 4'b0001;
      cycle("toggle_hi");
      mon = 4'b0000;
      cycle("toggle_lo");
    end
    read_reg(1'b0, 0);
    chk("acc0_is_15", 32'(rd_data), 32'd15);
    chk("sat0_clear", 32'(sat[0]), 32'd0);

    // saturation on ch1 and sat cleared by a write
    write_reg(1'b1, 1, 200);
    for (int k = 0; k < 2; k++) begin
      mon = 4'b0010;
      cycle("sat_hi");
      mon = 4'b0000;
      cycle("sat_lo");
    end
    read_reg(1'b0, 1);
    chk("acc1_sat_255", 32'(rd_data), 32'd255);
    chk("sat1_set", 32'(sat[1]), 32'd1);
    write_reg(1'b0, 1, 0);
    chk("sat1_cleared", 32'(sat[1]), 32'd0);

    // mon held high: one event per channel
    mon = 4'b1111;
    repeat (10) cycle("mon_held");
    mon = 4'b0000;
    cycle("mon_rel");
    read_reg(1'b0, 3);
    chk("acc3_one_event", 32'(rd_data), 32'd1);

    // accumulator write beats same-cycle event; unmapped read
    mon = 4'b0100;
    write_reg(1'b0, 2, 100);
    mon = 4'b0000;
    read_reg(1'b0, 2);
    chk("acc2_write_wins", 32'(rd_data), 32'd100);
    read_reg(1'b0, 7);
    chk("oob_rd_data", 32'(rd_data), 32'd0);
    chk("oob_rd_valid", 32'(rd_valid), 32'd1);

    // clear sweep with events during busy
    clr_all = 1'b1;
    cycle("clr_start");
    clr_all = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 20) begin
      bc++;
      mon = ~mon;
      cycle("clr_busy");
    end
    chk("busy_cycles", 32'(bc), 32'd4);
    mon = 4'b0000;
    cycle("clr_done");
    for (int i = 0; i < NUM_CH; i++) begin
      read_reg(1'b0, i);
      chk("acc_after_clear", 32'(rd_data), 32'd0);
    end

    // random traffic
    for (int k = 0; k < 400; k++) begin
      mon = NUM_CH'($urandom);
      enable = ($urandom_range(0, 3) != 0);
      wr_en = ($urandom_range(0, 5) == 0);
      sel = 1'($urandom);
      addr = ADDR_W'($urandom_range(0, 5));
      wr_data = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(240, 255)) : CNT_W'($urandom);
      rd_en = 1'($urandom);
      clr_all = ($urandom_range(0, 30) == 0);
      cycle("rand");
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr_all = 1'b0;
    mon = 4'b0000;
    while (busy === 1'b1 && bc < 100) begin
      bc++;
      cycle("rand_drain");
    end

    // reset during the second cycle of a sweep
    clr_all = 1'b1;
    cycle("clr2_start");
    clr_all = 1'b0;
    cycle("clr2_c1");
    #2;
    reset_L = 1'b0;
    mon = 4'b0101;
    model_reset();
    #1;
    chk("reset_busy_now", 32'(busy), 32'd0);
    check_outputs("midreset");
    @(posedge clk);
    #2;
    reset_L = 1'b1;
    cycle("release_events");
    mon = 4'b0000;
    cycle("release_lo");
    for (int i = 0; i < NUM_CH; i++) begin
      read_reg(1'b1, i);
      chk("weight_reset_1", 32'(rd_data), 32'd1);
    end
    read_reg(1'b0, 0);
    chk("acc0_release_evt", 32'(rd_data), 32'd1);
    read_reg(1'b0, 1);
    chk("acc1_no_evt", 32'(rd_data), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
